// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the IF-stage PC and sequences variable-latency imem fetches.
// Optional build macro FETCH_ALIGN_CHECK_EN traps misaligned redirect targets.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        branchTaken,
    input  logic [31:0] pcBranch,
    input  logic        jump,
    input  logic [31:0] pcJump,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    output logic [31:0] instruction,
    output logic [31:0] pc4Output,
    output logic        instrValid,
    output logic        flush,
    output logic        alignError
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        align_q, align_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        accept;
    logic        outstanding;
    logic        misalign;

    assign redirect = jump | branchTaken;
    assign target   = jump ? pcJump : pcBranch;
    assign pc_plus4 = pc_q + 32'd4;
    assign accept   = imemReq & imemReady;

    // A request is still owed a response unless it is being answered this cycle.
    assign outstanding = accept | ((state_q == WAIT) & ~imemValid);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = redirect & (target[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // State register: FSM, PC, skid buffer and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            skid_q    <= 32'd0;
            instr_q   <= 32'd0;
            pc4_q     <= 32'd0;
            valid_q   <= 1'b0;
            flush_q   <= 1'b0;
            align_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            skid_q    <= skid_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
            flush_q   <= flush_d;
            align_q   <= align_d;
        end
    end

    // Next-state logic: fetch sequencing, then redirect and freeze overrides.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        skid_d    = skid_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        valid_d   = hazard ? valid_q : 1'b0;
        flush_d   = 1'b0;
        align_d   = align_q;

        unique case (state_q)
            ISSUE: begin
                if (accept) begin
                    state_d   = WAIT;
                    discard_d = 1'b0;
                end
            end
            WAIT: begin
                if (imemValid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ISSUE;
                    end else if (!hazard) begin
                        instr_d = imemData;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = ISSUE;
                    end else begin
                        skid_d  = imemData;
                        pc_d    = pc_plus4;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // PC already advanced at skid time, so it is the held word's PC+4.
                if (!hazard) begin
                    instr_d = skid_q;
                    pc4_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase

        if (redirect) begin
            pc_d    = target;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
            flush_d = 1'b1;
            if (outstanding) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = ISSUE;
                discard_d = 1'b0;
            end
        end

        // A misaligned target parks the sequencer until reset.
        if (misalign) begin
            align_d = 1'b1;
        end
        if (misalign || align_q) begin
            state_d   = ISSUE;
            discard_d = 1'b0;
            valid_d   = 1'b0;
        end
    end

    // Output logic: request while issuing (unless parked), registered IF/ID bundle.
    always_comb begin
        imemReq     = (state_q == ISSUE) & ~align_q;
        imemAddr    = pc_q;
        instruction = instr_q;
        pc4Output   = pc4_q;
        instrValid  = valid_q;
        flush       = flush_q;
        alignError  = align_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed cycle table for fetch_sequencer plus corner sequences.
// Build with FETCH_ALIGN_CHECK_EN to exercise the misaligned-target trap.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        hazard;
    logic        branchTaken;
    logic [31:0] pcBranch;
    logic        jump;
    logic [31:0] pcJump;
    logic        imemReady;
    logic        imemValid;
    logic [31:0] imemData;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instruction;
    logic [31:0] pc4Output;
    logic        instrValid;
    logic        flush;
    logic        alignError;

    logic        w_imemReq;
    logic [31:0] w_imemAddr;
    logic [31:0] w_instruction;
    logic [31:0] w_pc4Output;
    logic        w_instrValid;
    logic        w_flush;
    logic        w_alignError;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset), .hazard(hazard),
        .branchTaken(branchTaken), .pcBranch(pcBranch),
        .jump(jump), .pcJump(pcJump),
        .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemValid(imemValid), .imemData(imemData),
        .instruction(instruction), .pc4Output(pc4Output),
        .instrValid(instrValid), .flush(flush), .alignError(alignError)
    );

    // Second instance in lockstep: same handshake, PC starts at the wrap point.
    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .hazard(hazard),
        .branchTaken(branchTaken), .pcBranch(pcBranch),
        .jump(jump), .pcJump(pcJump),
        .imemReq(w_imemReq), .imemAddr(w_imemAddr),
        .imemReady(imemReady), .imemValid(imemValid), .imemData(imemData),
        .instruction(w_instruction), .pc4Output(w_pc4Output),
        .instrValid(w_instrValid), .flush(w_flush), .alignError(w_alignError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hz;
        logic        br;
        logic [31:0] pb;
        logic        jp;
        logic [31:0] pj;
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] einstr;
        logic [31:0] epc4;
        logic        ev;
        logic        ef;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] md(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t v(
        input logic rst, input logic hz,
        input logic br, input logic [31:0] pb,
        input logic jp, input logic [31:0] pj,
        input logic rdy, input logic vld, input logic [31:0] dat,
        input logic ereq, input logic [31:0] eaddr,
        input logic [31:0] einstr, input logic [31:0] epc4,
        input logic ev, input logic ef);
        vec_t r;
        r.rst = rst; r.hz = hz; r.br = br; r.pb = pb;
        r.jp = jp; r.pj = pj; r.rdy = rdy; r.vld = vld; r.dat = dat;
        r.ereq = ereq; r.eaddr = eaddr; r.einstr = einstr;
        r.epc4 = epc4; r.ev = ev; r.ef = ef;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset       = t.rst;
        hazard      = t.hz;
        branchTaken = t.br;
        pcBranch    = t.pb;
        jump        = t.jp;
        pcJump      = t.pj;
        imemReady   = t.rdy;
        imemValid   = t.vld;
        imemData    = t.dat;
    endtask

    initial begin
        reset = 1'b1; hazard = 1'b0;
        branchTaken = 1'b0; pcBranch = 32'd0;
        jump = 1'b0; pcJump = 32'd0;
        imemReady = 1'b0; imemValid = 1'b0; imemData = 32'd0;

        // rst hz br pb jp pj rdy vld dat | req addr instr pc4 valid flush
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h100,0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h100), 0,32'h100,0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h104,md(32'h100),32'h104,1,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h104), 0,32'h104,md(32'h100),32'h104,0,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h108,md(32'h104),32'h108,1,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h108), 0,32'h108,md(32'h104),32'h108,0,0));
        tv.push_back(v(0,1,0,0,0,0,1,0,0,        1,32'h10C,md(32'h108),32'h10C,1,0));
        tv.push_back(v(0,1,0,0,0,0,0,1,md(32'h10C), 0,32'h10C,md(32'h108),32'h10C,1,0));
        tv.push_back(v(0,1,0,0,0,0,1,0,0,        0,32'h110,md(32'h108),32'h10C,1,0));
        tv.push_back(v(0,1,0,0,0,0,1,0,0,        0,32'h110,md(32'h108),32'h10C,1,0));
        tv.push_back(v(0,1,0,0,0,0,1,0,0,        0,32'h110,md(32'h108),32'h10C,1,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        0,32'h110,md(32'h108),32'h10C,1,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h110,md(32'h10C),32'h110,1,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h110), 0,32'h110,md(32'h10C),32'h110,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,0,0,        1,32'h114,md(32'h110),32'h114,1,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h114,md(32'h110),32'h114,0,0));
        tv.push_back(v(0,0,1,32'h400,0,0,0,0,0,  0,32'h114,md(32'h110),32'h114,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,0,0,        0,32'h400,md(32'h110),32'h114,0,1));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h114), 0,32'h400,md(32'h110),32'h114,0,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h400,md(32'h110),32'h114,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h400), 0,32'h400,md(32'h110),32'h114,0,0));
        tv.push_back(v(0,0,1,32'h400,1,32'h800,1,0,0, 1,32'h404,md(32'h400),32'h404,1,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h404), 0,32'h800,md(32'h400),32'h404,0,1));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h800,md(32'h400),32'h404,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h800), 0,32'h800,md(32'h400),32'h404,0,0));
        tv.push_back(v(0,1,1,32'h300,0,0,0,0,0,  1,32'h804,md(32'h800),32'h804,1,0));
        tv.push_back(v(0,0,0,0,1,32'h500,0,0,0,  1,32'h300,md(32'h800),32'h804,0,1));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h500,md(32'h800),32'h804,0,1));
        tv.push_back(v(0,0,1,32'h600,0,0,0,1,md(32'h500), 0,32'h500,md(32'h800),32'h804,0,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h600,md(32'h800),32'h804,0,1));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'h600), 0,32'h600,md(32'h800),32'h804,0,0));
        tv.push_back(v(0,0,0,0,1,32'hFFFF_FFFC,0,0,0, 1,32'h604,md(32'h600),32'h604,1,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'hFFFF_FFFC,md(32'h600),32'h604,0,1));
        tv.push_back(v(0,0,0,0,0,0,0,1,md(32'hFFFF_FFFC), 0,32'hFFFF_FFFC,md(32'h600),32'h604,0,0));
        tv.push_back(v(0,0,0,0,0,0,1,0,0,        1,32'h0,md(32'hFFFF_FFFC),32'h0,1,0));
        tv.push_back(v(1,0,0,0,0,0,0,0,0,        0,32'h0,md(32'hFFFF_FFFC),32'h0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,1,32'hDEAD_BEEF, 1,32'h100,0,0,0,0));
        tv.push_back(v(0,0,0,0,0,0,0,0,0,        1,32'h100,0,0,0,0));

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            chk($sformatf("row%0d imemReq", i), 32'(imemReq), 32'(tv[i].ereq));
            chk($sformatf("row%0d imemAddr", i), imemAddr, tv[i].eaddr);
            chk($sformatf("row%0d instruction", i), instruction, tv[i].einstr);
            chk($sformatf("row%0d pc4Output", i), pc4Output, tv[i].epc4);
            chk($sformatf("row%0d instrValid", i), 32'(instrValid), 32'(tv[i].ev));
            chk($sformatf("row%0d flush", i), 32'(flush), 32'(tv[i].ef));
            chk($sformatf("row%0d alignError", i), 32'(alignError), 32'd0);
            if (i == 0) begin
                chk("wrap reset imemAddr", w_imemAddr, 32'hFFFF_FFFC);
            end
            if (i == 2) begin
                chk("wrap pc4Output", w_pc4Output, 32'h0);
                chk("wrap next imemAddr", w_imemAddr, 32'h0);
                chk("wrap instrValid", 32'(w_instrValid), 32'd1);
            end
            drive(tv[i]);
            @(negedge clk);
        end

        // Misaligned jump target from ISSUE without acceptance.
        drive(v(0,0,0,0,1,32'h802,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        chk("misalign flush", 32'(flush), 32'd1);
        chk("misalign instrValid", 32'(instrValid), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign alignError", 32'(alignError), 32'd1);
        chk("misalign imemReq", 32'(imemReq), 32'd0);
`else
        chk("misalign alignError", 32'(alignError), 32'd0);
        chk("misalign imemReq", 32'(imemReq), 32'd1);
        chk("misalign imemAddr", imemAddr, 32'h802);
`endif
        drive(v(0,0,0,0,0,0,1,1,32'h1234_5678, 0,0,0,0,0,0));
        @(negedge clk);
        chk("after misalign flush", 32'(flush), 32'd0);
        chk("after misalign instrValid", 32'(instrValid), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("sticky alignError", 32'(alignError), 32'd1);
        chk("frozen imemReq", 32'(imemReq), 32'd0);
`else
        chk("no alignError", 32'(alignError), 32'd0);
        chk("fetch at target imemReq", 32'(imemReq), 32'd0);
        chk("fetch at target imemAddr", imemAddr, 32'h802);
`endif
        drive(v(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        drive(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        chk("reset clears alignError", 32'(alignError), 32'd0);
        chk("reset imemReq", 32'(imemReq), 32'd1);
        chk("reset imemAddr", imemAddr, 32'h100);
        chk("reset flush", 32'(flush), 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
